// File: rtl/row_col_dec_5x5.sv
// Decoder/monitor for the 5x5 DCO capacitor-array select triple (r_all/row/col).
// Rebuilds the binary tuning word, flags overflow and illegal codes, and counts errors.
module row_col_dec_5x5 #(
  parameter int MAX      = 25,
  parameter int OVF_WORD = 31,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [4:0]       r_all,
  input  logic [4:0]       row,
  input  logic [4:0]       col,
  input  logic             clr_err,
  output logic [4:0]       word_out,
  output logic             out_vld,
  output logic             ovf,
  output logic             illegal,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [4:0] MAX_W = 5'(MAX);
  localparam logic [4:0] OVF_W = 5'(OVF_WORD);

  function automatic logic [2:0] popcnt(input logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [4:0] lsb_therm(input logic [2:0] n);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) if (i < int'(n)) m[i] = 1'b1;
    return m;
  endfunction

  // Odd rows are filled from the MSB side because the array is wired serpentine.
  function automatic logic [4:0] msb_therm(input logic [2:0] n);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) if (i >= 5 - int'(n)) m[i] = 1'b1;
    return m;
  endfunction

  logic [4:0] s1_r_all, s1_row, s1_col;
  logic       s1_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r_all <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_vld   <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_r_all <= r_all;
        s1_row   <= row;
        s1_col   <= col;
      end
    end
  end

  logic [2:0] k, c;
  logic [4:0] sum;
  logic       is_ovf, is_idle, col_ok, c_ok, is_legal, bad;

  always_comb begin
    k        = popcnt(s1_r_all);
    c        = popcnt(s1_col);
    sum      = {k, 2'b00} + {2'b00, k} + {2'b00, c};
    is_ovf   = &s1_r_all;
    is_idle  = (s1_r_all == 5'd0) && (s1_row == 5'd0) && (s1_col == 5'd0);
    col_ok   = k[0] ? (s1_col == msb_therm(c)) : (s1_col == lsb_therm(c));
    // c=0 above row 0 is the non-canonical form of (k-1, c=5).
    c_ok     = (c != 3'd0) || (k == 3'd0);
    is_legal = is_idle ||
               ((k <= 3'd4) && (s1_r_all == lsb_therm(k)) &&
                (s1_row == (5'b00001 << k)) && col_ok && c_ok && (sum <= MAX_W));
    bad      = !is_ovf && !is_legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out   <= '0;
      out_vld    <= 1'b0;
      ovf        <= 1'b0;
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        ovf     <= is_ovf;
        illegal <= bad;
        if (is_ovf)        word_out <= OVF_W;
        else if (is_legal) word_out <= sum;
      end
      if (clr_err) begin
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end else if (s1_vld && bad) begin
        err_sticky <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
